serial_subtractor: RTL and testbench

Bit-serial W-bit subtractor that computes D = A - B with a borrow-out, one bit per clock, LSB first. It is the inverse-direction companion to the team's combinational four-bit adder, and shares that adder's operand/result conventions (A, B in; result plus carry/borrow out). A start/busy/done handshake lets a controller or bench launch an operation and collect the result.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks.
//   DEFAULT_W : default operand/result width
//   state_t   : handshake FSM states (IDLE, RUN, DONE)
package serial_arith_defs;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit combinational full subtractor: d = a - b - bin.
// Ports:
//   a, b  : operand bits (minuend, subtrahend)
//   bin   : borrow in from the less significant bit
//   d     : difference bit
//   bout  : borrow out to the more significant bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when the bits match and a
  // borrow is already pending from below.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: D = A - B, LSB first, one bit per clock.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : launch request, accepted in IDLE or DONE
//   A, B     : minuend / subtrahend, sampled on the accepting edge
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when D/Bout take a new result
//   D, Bout  : difference modulo 2^W and borrow out (A < B)
module serial_subtractor
  import serial_arith_defs::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] D,
  output logic         Bout
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   ra_q, ra_d;
  logic [W-1:0]   rb_q, rb_d;
  logic           borrow_q, borrow_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   d_q, d_d;
  logic           bout_q, bout_d;

  logic           fs_d;
  logic           fs_bout;

  full_subtractor u_fs (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state logic. Each difference bit is shifted into the MSB that
  // the minuend register vacates, so ra doubles as the result
  // accumulator: after W shifts it holds the complete difference.
  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          ra_d     = A;
          rb_d     = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        ra_d     = {fs_d, ra_q[W-1:1]};
        rb_d     = rb_q >> 1;
        borrow_d = fs_bout;
        if (cnt_q == CNT_LAST) begin
          d_d     = {fs_d, ra_q[W-1:1]};
          bout_d  = fs_bout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign D    = d_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4, d4;
  logic [7:0] a8, b8, d8;
  logic       busy4, done4, bout4;
  logic       busy8, done8, bout8;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_subtractor #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
  );

  serial_subtractor #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic.
  function automatic int exp_diff(input int a, input int b, input int w);
    return (a - b) & ((1 << w) - 1);
  endfunction

  function automatic bit exp_borrow(input int a, input int b);
    return a < b;
  endfunction

  // Present operands with start for one edge; returns just after that edge.
  task automatic launch(input bit use8, input int a, input int b);
    if (use8) begin a8 = 8'(a); b8 = 8'(b); start8 = 1'b1; end
    else      begin a4 = 4'(a); b4 = 4'(b); start4 = 1'b1; end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done; reports edges waited, busy cycles seen and
  // whether D stayed at its previous value until the done cycle.
  task automatic wait_done(input bit use8, output int edges, output int busy_cycles,
                           output bit held, output bit timed_out);
    logic [15:0] d0;
    d0 = use8 ? {8'h00, d8} : {12'h000, d4};
    edges = 0; busy_cycles = 0; held = 1'b1; timed_out = 1'b0;
    while (!(use8 ? done8 : done4)) begin
      if (use8 ? busy8 : busy4) busy_cycles++;
      if ((use8 ? {8'h00, d8} : {12'h000, d4}) !== d0) held = 1'b0;
      @(posedge clk); #1;
      edges++;
      if (edges > 64) begin timed_out = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    tests_run++;
    if ({busy4, done4, d4, bout4, busy8, done8, d8, bout8} !== 22'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: got %b required all zero",
               {busy4, done4, d4, bout4, busy8, done8, d8, bout8});
    end
    start4 = 1'b1; start8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy4, done4, d4, bout4, busy8, done8, d8, bout8} !== 22'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_held: got %b required all zero",
               {busy4, done4, d4, bout4, busy8, done8, d8, bout8});
    end
    start4 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int edges, busy_cycles; bit held, to;
    launch(1'b0, 3, 4);
    wait_done(1'b0, edges, busy_cycles, held, to);
    tests_run++;
    if (to || edges !== 4) begin
      tests_failed++;
      $display("[TB] FAIL latency: done after %0d edges (timeout=%0d) required 4", edges, to);
    end
    tests_run++;
    if (busy_cycles !== 4) begin
      tests_failed++;
      $display("[TB] FAIL busy_len: got %0d cycles required 4", busy_cycles);
    end
    tests_run++;
    if (d4 !== 4'hF || bout4 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL latency_result: got D=%h Bout=%b required D=f Bout=1", d4, bout4);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL done_pulse: got done=%b busy=%b required 0 0", done4, busy4);
    end
  endtask

  task automatic test_back_to_back;
    int ta[4] = '{9, 15, 0, 10};
    int tb_[4] = '{2, 15, 5, 10};
    int edges, busy_cycles; bit held, to;
    launch(1'b0, ta[0], tb_[0]);
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b0, edges, busy_cycles, held, to);
      tests_run++;
      if (to || edges !== 4 || d4 !== 4'(exp_diff(ta[i], tb_[i], 4)) ||
          bout4 !== exp_borrow(ta[i], tb_[i])) begin
        tests_failed++;
        $display("[TB] FAIL b2b_%0d: got D=%h Bout=%b edges=%0d required D=%h Bout=%b edges=4",
                 i, d4, bout4, edges, exp_diff(ta[i], tb_[i], 4), exp_borrow(ta[i], tb_[i]));
      end
      if (i < 3) begin
        launch(1'b0, ta[i+1], tb_[i+1]);
        tests_run++;
        if (busy4 !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL b2b_nobubble_%0d: got busy=%b required 1", i, busy4);
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    int edges, busy_cycles; bit held, to;
    @(posedge clk); #1;
    launch(1'b0, 0, 15);
    @(posedge clk); #1;
    a4 = 4'd7; b4 = 4'd1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done(1'b0, edges, busy_cycles, held, to);
    tests_run++;
    if (to || edges + 2 !== 4 || d4 !== 4'h1 || bout4 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_ignored: got D=%h Bout=%b edges=%0d required D=1 Bout=1 edges=4",
               d4, bout4, edges + 2);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL no_requeue: got busy=%b required 0", busy4);
    end
  endtask

  task automatic test_async_reset;
    int edges, busy_cycles; bit held, to;
    bit saw_done;
    launch(1'b0, 9, 2);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || d4 !== 4'h0 || bout4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_midrun: got busy=%b done=%b D=%h Bout=%b required 0 0 0 0",
               busy4, done4, d4, bout4);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done4 || busy4) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done) begin
      tests_failed++;
      $display("[TB] FAIL reset_abandon: got activity after reset required none");
    end
    launch(1'b0, 6, 3);
    wait_done(1'b0, edges, busy_cycles, held, to);
    tests_run++;
    if (to || d4 !== 4'h3 || bout4 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL after_reset: got D=%h Bout=%b required D=3 Bout=0", d4, bout4);
    end
  endtask

  task automatic test_width8;
    int edges, busy_cycles; bit held, to;
    launch(1'b1, 8'h00, 8'h01);
    wait_done(1'b1, edges, busy_cycles, held, to);
    tests_run++;
    if (to || edges !== 8 || d8 !== 8'hFF || bout8 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL w8_first: got D=%h Bout=%b edges=%0d required D=ff Bout=1 edges=8",
               d8, bout8, edges);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (d8 !== 8'hFF || bout8 !== 1'b1 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL w8_idle_hold: got D=%h Bout=%b busy=%b required D=ff Bout=1 busy=0",
               d8, bout8, busy8);
    end
    launch(1'b1, 8'hC8, 8'h64);
    wait_done(1'b1, edges, busy_cycles, held, to);
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("[TB] FAIL w8_run_hold: got D changed before done required held");
    end
    tests_run++;
    if (to || d8 !== 8'h64 || bout8 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL w8_second: got D=%h Bout=%b required D=64 Bout=0", d8, bout8);
    end
  endtask

  task automatic test_random(input bit use8, input int n);
    int w, a, b, edges, busy_cycles; bit held, to;
    int got_d; bit got_b;
    w = use8 ? 8 : 4;
    for (int i = 0; i < n; i++) begin
      a = int'($urandom_range((1 << w) - 1, 0));
      b = int'($urandom_range((1 << w) - 1, 0));
      launch(use8, a, b);
      wait_done(use8, edges, busy_cycles, held, to);
      got_d = use8 ? int'(d8) : int'(d4);
      got_b = use8 ? bout8 : bout4;
      tests_run++;
      if (to || edges !== w || got_d !== exp_diff(a, b, w) || got_b !== exp_borrow(a, b)) begin
        tests_failed++;
        $display("[TB] FAIL random_w%0d_%0d: %0d-%0d got D=%0d Bout=%b edges=%0d required D=%0d Bout=%b edges=%0d",
                 w, i, a, b, got_d, got_b, edges, exp_diff(a, b, w), exp_borrow(a, b), w);
      end
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_width8();
    test_random(1'b0, 20);
    test_random(1'b1, 20);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
